// File: rtl/divisor_sequencial.sv
// divisor_sequencial
//   Sequential restoring divider, one quotient bit per clock under a
//   start/done handshake. The unsigned N_DVD-bit dividend is divided by an
//   N_DVS-bit divisor. The result is an N_DVD-bit quotient and an N_DVS-bit
//   remainder.
//
//   Optional build macro: DIV_ZERO_CHECK_EN
//     defined   : a zero divisor skips CALC (IDLE -> FIM) and sets div_zero
//     undefined : no zero check, div_zero tied low; a zero divisor runs the
//                 full loop and yields quotient all ones, remainder = low bits
//
//   Ports
//     CLOCK_50   in   system clock, rising edge
//     RST_N      in   asynchronous active-low reset
//     start      in   request, sampled only in IDLE
//     dividendo  in   dividend, captured on the accepting edge
//     divisor    in   divisor, captured on the accepting edge
//     busy       out  high in CALC and FIM
//     done       out  one-cycle pulse, results valid
//     quociente  out  quotient, held until the next completion
//     resto      out  remainder, held until the next completion
//     div_zero   out  divide-by-zero flag, held with results
//
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | one shift/subtract step per edge, N_DVD steps
//   FIM   | results loaded; done is raised on the edge leaving FIM
module divisor_sequencial #(
    parameter int N_DVD = 10,
    parameter int N_DVS = 5
) (
    input  logic             CLOCK_50,
    input  logic             RST_N,
    input  logic             start,
    input  logic [N_DVD-1:0] dividendo,
    input  logic [N_DVS-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [N_DVD-1:0] quociente,
    output logic [N_DVS-1:0] resto,
    output logic             div_zero
);

    localparam int CW = $clog2(N_DVD + 1);
    localparam logic [CW-1:0] LAST = CW'(N_DVD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIM  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [N_DVS:0]   rem_q;
    logic [N_DVD-1:0] quo_q;
    logic [N_DVS-1:0] dvs_q;
    logic [CW-1:0]    cnt;
    logic             done_q;

    logic [N_DVS:0]   rem_sh;
    logic [N_DVS:0]   rem_nxt;
    logic [N_DVD-1:0] quo_nxt;
    logic             fits;
    logic             last_step;
    logic             zero_fast;

    // One restoring step. The partial remainder is one bit wider than the
    // divisor so that the shifted value can never overflow before the compare.
    always_comb begin
        rem_sh    = {rem_q[N_DVS-1:0], quo_q[N_DVD-1]};
        fits      = (rem_sh >= {1'b0, dvs_q});
        rem_nxt   = fits ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        quo_nxt   = {quo_q[N_DVD-2:0], fits};
        last_step = (cnt == LAST);
    end

`ifdef DIV_ZERO_CHECK_EN
    assign zero_fast = (divisor == '0);
`else
    assign zero_fast = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = zero_fast ? FIM : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = FIM;
                end
            end
            FIM:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DIV_ZERO_CHECK_EN
    logic div_zero_q;
`endif

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt        <= '0;
            done_q     <= 1'b0;
            quociente  <= '0;
            resto      <= '0;
`ifdef DIV_ZERO_CHECK_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            // done follows FIM by one edge, so it rises together with IDLE.
            done_q <= (state == FIM);
            case (state)
                IDLE: begin
                    if (start) begin
                        dvs_q <= divisor;
                        rem_q <= '0;
                        quo_q <= dividendo;
                        cnt   <= '0;
`ifdef DIV_ZERO_CHECK_EN
                        if (zero_fast) begin
                            quociente  <= '1;
                            resto      <= dividendo[N_DVS-1:0];
                            div_zero_q <= 1'b1;
                        end
`endif
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        quociente  <= quo_nxt;
                        resto      <= rem_nxt[N_DVS-1:0];
`ifdef DIV_ZERO_CHECK_EN
                        div_zero_q <= 1'b0;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == CALC) || (state == FIM);
    assign done = done_q;

`ifdef DIV_ZERO_CHECK_EN
    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divisor_sequencial.sv
module tb_divisor_sequencial;

    logic       CLOCK_50;
    logic       RST_N;
    logic       start;
    logic [9:0] dividendo;
    logic [4:0] divisor;
    logic       busy;
    logic       done;
    logic [9:0] quociente;
    logic [4:0] resto;
    logic       div_zero;

    int checks;
    int errors;

    divisor_sequencial #(.N_DVD(10), .N_DVS(5)) dut (
        .CLOCK_50  (CLOCK_50),
        .RST_N     (RST_N),
        .start     (start),
        .dividendo (dividendo),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quociente (quociente),
        .resto     (resto),
        .div_zero  (div_zero)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

`ifdef DIV_ZERO_CHECK_EN
    localparam int DZ_EDGES = 2;
    localparam logic DZ_FLAG = 1'b1;
`else
    localparam int DZ_EDGES = 12;
    localparam logic DZ_FLAG = 1'b0;
`endif

    // Stimulus only: one start pulse, then count edges (accepting edge = 1)
    // until done is seen.
    task automatic run_op(input logic [9:0] a, input logic [4:0] b,
                          output int edges, output bit got, output logic busy_after);
        @(negedge CLOCK_50);
        dividendo = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start      = 1'b0;
        busy_after = busy;
        edges      = 1;
        got        = 1'b0;
        while (!got && edges < 40) begin
            @(posedge CLOCK_50);
            #1;
            edges++;
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, done, quociente, resto, div_zero} !== 18'd0) begin
            errors++;
            $display("FAIL reset_in: got busy=%b done=%b q=%0d r=%0d dz=%b, need all 0",
                     busy, done, quociente, resto, div_zero);
        end
        @(negedge CLOCK_50);
        RST_N = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        checks++;
        if ({busy, done, quociente, resto, div_zero} !== 18'd0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b q=%0d r=%0d dz=%b, need all 0",
                     busy, done, quociente, resto, div_zero);
        end
    endtask

    task automatic test_basic;
        int edges; bit got; logic b_after;
        run_op(10'd1000, 5'd7, edges, got, b_after);
        checks++;
        if (b_after !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b, need 1", b_after);
        end
        checks++;
        if (!got || edges != 12) begin
            errors++; $display("FAIL basic_latency: got done=%0d edges=%0d, need done at 12", got, edges);
        end
        checks++;
        if (quociente !== 10'd142 || resto !== 5'd6) begin
            errors++; $display("FAIL basic_result: got q=%0d r=%0d, need q=142 r=6", quociente, resto);
        end
        checks++;
        if (busy !== 1'b0 || div_zero !== 1'b0) begin
            errors++; $display("FAIL basic_busy_done: got busy=%b dz=%b, need 0 0", busy, div_zero);
        end
        @(posedge CLOCK_50);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL basic_pulse: got done=%b next cycle, need 0", done);
        end
    endtask

    task automatic test_boundaries;
        logic [9:0] va [4] = '{10'd1023, 10'd5, 10'd0, 10'd1023};
        logic [4:0] vb [4] = '{5'd31, 5'd31, 5'd1, 5'd1};
        logic [9:0] eq [4] = '{10'd33, 10'd0, 10'd0, 10'd1023};
        logic [4:0] er [4] = '{5'd0, 5'd5, 5'd0, 5'd0};
        for (int i = 0; i < 4; i++) begin
            int edges; bit got; logic b_after;
            run_op(va[i], vb[i], edges, got, b_after);
            checks++;
            if (!got || edges != 12 || quociente !== eq[i] || resto !== er[i]) begin
                errors++;
                $display("FAIL boundary_%0d (%0d/%0d): got done=%0d edges=%0d q=%0d r=%0d, need edges=12 q=%0d r=%0d",
                         i, va[i], vb[i], got, edges, quociente, resto, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n, d1, d2;
        bit unstable;
        n = 0; d1 = 0; d2 = 0; unstable = 1'b0;
        @(negedge CLOCK_50);
        dividendo = 10'd100;
        divisor   = 5'd9;
        start     = 1'b1;
        while (d2 == 0 && n < 60) begin
            @(posedge CLOCK_50);
            #1;
            n++;
            if (done === 1'b1) begin
                if (d1 == 0) d1 = n;
                else begin
                    d2 = n;
                    start = 1'b0;
                end
                checks++;
                if (quociente !== 10'd11 || resto !== 5'd1) begin
                    errors++;
                    $display("FAIL b2b_result: got q=%0d r=%0d at edge %0d, need q=11 r=1", quociente, resto, n);
                end
            end else if (d1 != 0) begin
                if (quociente !== 10'd11 || resto !== 5'd1) unstable = 1'b1;
            end
        end
        start = 1'b0;
        checks++;
        if (d1 != 12 || d2 - d1 != 12) begin
            errors++;
            $display("FAIL b2b_spacing: got first=%0d second=%0d, need 12 and 24", d1, d2);
        end
        checks++;
        if (unstable) begin
            errors++; $display("FAIL b2b_hold: got results changing between pulses, need q=11 r=1 held");
        end
    endtask

    task automatic test_start_busy;
        int n_done;
        @(negedge CLOCK_50);
        dividendo = 10'd1000;
        divisor   = 5'd7;
        start     = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start  = 1'b0;
        n_done = 0;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        dividendo = 10'd50;
        divisor   = 5'd3;
        start     = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        if (done === 1'b1) n_done++;
        repeat (30) begin
            @(posedge CLOCK_50);
            #1;
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 1) begin
            errors++; $display("FAIL busy_start_count: got %0d done pulses, need 1", n_done);
        end
        checks++;
        if (quociente !== 10'd142 || resto !== 5'd6) begin
            errors++; $display("FAIL busy_start_result: got q=%0d r=%0d, need q=142 r=6", quociente, resto);
        end
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        int edges; bit got; logic b_after;
        saw_done = 1'b0;
        @(negedge CLOCK_50);
        dividendo = 10'd1000;
        divisor   = 5'd7;
        start     = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        repeat (4) @(posedge CLOCK_50);
        #1;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({busy, done, quociente, resto, div_zero} !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b q=%0d r=%0d dz=%b, need all 0",
                     busy, done, quociente, resto, div_zero);
        end
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RST_N = 1'b1;
        repeat (15) begin
            @(posedge CLOCK_50);
            #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL reset_mid_nodone: got done/busy after reset, need none");
        end
        run_op(10'd1000, 5'd7, edges, got, b_after);
        checks++;
        if (!got || edges != 12 || quociente !== 10'd142 || resto !== 5'd6) begin
            errors++;
            $display("FAIL reset_mid_rerun: got done=%0d edges=%0d q=%0d r=%0d, need edges=12 q=142 r=6",
                     got, edges, quociente, resto);
        end
    endtask

    task automatic test_div_zero;
        int edges; bit got; logic b_after;
        run_op(10'd77, 5'd0, edges, got, b_after);
        checks++;
        if (!got || edges != DZ_EDGES) begin
            errors++; $display("FAIL dz_latency: got done=%0d edges=%0d, need %0d", got, edges, DZ_EDGES);
        end
        checks++;
        if (quociente !== 10'd1023 || resto !== 5'd13 || div_zero !== DZ_FLAG) begin
            errors++;
            $display("FAIL dz_result: got q=%0d r=%0d dz=%b, need q=1023 r=13 dz=%b",
                     quociente, resto, div_zero, DZ_FLAG);
        end
        run_op(10'd20, 5'd4, edges, got, b_after);
        checks++;
        if (!got || edges != 12 || quociente !== 10'd5 || resto !== 5'd0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL dz_clear: got done=%0d edges=%0d q=%0d r=%0d dz=%b, need edges=12 q=5 r=0 dz=0",
                     got, edges, quociente, resto, div_zero);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        RST_N     = 1'b0;
        start     = 1'b0;
        dividendo = '0;
        divisor   = '0;
        #35;
        test_reset;
        test_basic;
        test_boundaries;
        test_back_to_back;
        test_start_busy;
        test_reset_mid;
        test_div_zero;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
